// File: rtl/frame_read_scheduler_pkg.sv
// Shared types and default geometry for the SD-read frame read scheduler.
package frame_read_scheduler_pkg;

  // Scheduler control states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACK   = 2'd1,
    ISSUE = 2'd2,
    DRAIN = 2'd3
  } state_e;

  // Default display geometry and memory interface sizing
  localparam int unsigned DEF_LINE_PIXELS = 1024;
  localparam int unsigned DEF_FRAME_LINES = 768;
  localparam int unsigned DEF_BURST_LEN   = 64;
  localparam int unsigned DEF_FIFO_DEPTH  = 512;
  localparam int unsigned DEF_ADDR_WIDTH  = 24;

  localparam int unsigned FRAME_WORDS      = DEF_LINE_PIXELS * DEF_FRAME_LINES;
  localparam int unsigned BURSTS_PER_FRAME = FRAME_WORDS / DEF_BURST_LEN;
  localparam int unsigned LEVEL_W          = $clog2(DEF_FIFO_DEPTH) + 1;
  localparam int unsigned LEN_W            = $clog2(DEF_BURST_LEN) + 1;

  // Width of a counter that must hold values 0..max_val
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return $clog2(max_val) + 1;
  endfunction

endpackage

// File: rtl/frame_read_scheduler_rd_credit_counter.sv
// Tracks read words still in flight and decides whether another burst fits in the pixel FIFO.
module rd_credit_counter
  import frame_read_scheduler_pkg::*;
#(
  parameter int unsigned BURST_LEN  = DEF_BURST_LEN,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int unsigned LVL_W      = $clog2(DEF_FIFO_DEPTH) + 1
) (
  input  logic             video_clk,
  input  logic             rst_n,
  input  logic             add,
  input  logic             rd_data_valid,
  input  logic [LVL_W-1:0] fifo_level,
  output logic [LVL_W-1:0] outstanding,
  output logic             has_space_c
);

  localparam int unsigned SUM_W = LVL_W + 2;

  logic [LVL_W-1:0] outstanding_nxt;

  // Next in-flight count: add a burst on accept, retire one word per return, never below zero
  always_comb begin
    outstanding_nxt = outstanding;
    if (add) begin
      outstanding_nxt = outstanding_nxt + LVL_W'(BURST_LEN);
    end
    if (rd_data_valid && (outstanding_nxt != '0)) begin
      outstanding_nxt = outstanding_nxt - LVL_W'(1);
    end
  end

  // Space check against the count as it will stand after this cycle
  always_comb begin
    has_space_c = (SUM_W'(fifo_level) + SUM_W'(outstanding_nxt) + SUM_W'(BURST_LEN))
                  <= SUM_W'(FIFO_DEPTH);
  end

  // In-flight word counter register
  always_ff @(posedge video_clk) begin
    if (!rst_n) begin
      outstanding <= '0;
    end else begin
      outstanding <= outstanding_nxt;
    end
  end

endmodule

// File: rtl/frame_read_scheduler.sv
// Per-frame burst read scheduler for a ping-pong frame buffer pair.
module frame_read_scheduler
  import frame_read_scheduler_pkg::*;
#(
  parameter int unsigned          LINE_PIXELS = DEF_LINE_PIXELS,
  parameter int unsigned          FRAME_LINES = DEF_FRAME_LINES,
  parameter int unsigned          BURST_LEN   = DEF_BURST_LEN,
  parameter int unsigned          FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int unsigned          ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR0 = '0,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR1 = 24'h100000
) (
  input  logic                             video_clk,
  input  logic                             rst_n,
  input  logic                             read_req,
  output logic                             read_req_ack,
  input  logic                             wr_frame_done,
  output logic                             cmd_valid,
  input  logic                             cmd_ready,
  output logic [ADDR_WIDTH-1:0]            cmd_addr,
  output logic [$clog2(BURST_LEN):0]       cmd_len,
  input  logic [$clog2(FIFO_DEPTH):0]      fifo_level,
  input  logic                             rd_data_valid,
  output logic                             frame_buf_sel,
  output logic                             busy,
  output logic                             overrun,
  output logic [15:0]                      frame_cnt
);

  localparam int unsigned FRM_WORDS  = LINE_PIXELS * FRAME_LINES;
  localparam int unsigned FRM_BURSTS = FRM_WORDS / BURST_LEN;
  localparam int unsigned LVL_W      = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned BLEN_W     = $clog2(BURST_LEN) + 1;
  localparam int unsigned BCNT_W     = cnt_w(FRM_BURSTS);

  state_e            state;
  logic [BCNT_W-1:0] bursts_left;
  logic              swap_pending;
  logic [LVL_W-1:0]  outstanding;
  logic              has_space_c;
  logic              accept_c;

  // Base word address of a ping-pong buffer
  function automatic logic [ADDR_WIDTH-1:0] base_of(input logic sel);
    return sel ? BASE_ADDR1 : BASE_ADDR0;
  endfunction

  assign cmd_len = BLEN_W'(BURST_LEN);

  // A burst command handshake completes this cycle
  always_comb begin
    accept_c = (state == ISSUE) && cmd_valid && cmd_ready;
  end

  rd_credit_counter #(
    .BURST_LEN  (BURST_LEN),
    .FIFO_DEPTH (FIFO_DEPTH),
    .LVL_W      (LVL_W)
  ) u_credit (
    .video_clk     (video_clk),
    .rst_n         (rst_n),
    .add           (accept_c),
    .rd_data_valid (rd_data_valid),
    .fifo_level    (fifo_level),
    .outstanding   (outstanding),
    .has_space_c   (has_space_c)
  );

  // Frame control FSM with registered outputs
  always_ff @(posedge video_clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      read_req_ack  <= 1'b0;
      cmd_valid     <= 1'b0;
      cmd_addr      <= BASE_ADDR0;
      frame_buf_sel <= 1'b0;
      busy          <= 1'b0;
      overrun       <= 1'b0;
      frame_cnt     <= 16'd0;
      swap_pending  <= 1'b0;
      bursts_left   <= '0;
    end else begin
      read_req_ack <= 1'b0;

      // A completed back buffer is remembered until the next frame start
      if (wr_frame_done && (state != ACK)) begin
        swap_pending <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (read_req) begin
            state        <= ACK;
            read_req_ack <= 1'b1;
            busy         <= 1'b1;
          end
        end

        ACK: begin
          bursts_left <= BCNT_W'(FRM_BURSTS);
          cmd_valid   <= has_space_c;
          state       <= ISSUE;
          if (swap_pending || wr_frame_done) begin
            frame_buf_sel <= ~frame_buf_sel;
            swap_pending  <= 1'b0;
            cmd_addr      <= base_of(~frame_buf_sel);
          end else begin
            cmd_addr <= base_of(frame_buf_sel);
          end
        end

        ISSUE: begin
          if (read_req) begin
            overrun <= 1'b1;
          end
          // A presented command holds address and valid until accepted
          if (accept_c) begin
            cmd_addr    <= cmd_addr + ADDR_WIDTH'(BURST_LEN);
            bursts_left <= bursts_left - BCNT_W'(1);
            if (bursts_left == BCNT_W'(1)) begin
              cmd_valid <= 1'b0;
              state     <= DRAIN;
            end else begin
              cmd_valid <= has_space_c;
            end
          end else if (!cmd_valid) begin
            cmd_valid <= has_space_c;
          end
        end

        DRAIN: begin
          if (read_req) begin
            overrun <= 1'b1;
          end
          if (outstanding == '0) begin
            frame_cnt <= frame_cnt + 16'd1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_read_scheduler.sv
// Directed self-checking bench for frame_read_scheduler with a small memory return model.
module tb_frame_read_scheduler;

  logic        video_clk = 1'b0;
  logic        rst_n;
  logic        read_req;
  logic        read_req_ack;
  logic        wr_frame_done;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [23:0] cmd_addr;
  logic [3:0]  cmd_len;
  logic [5:0]  fifo_level;
  logic        rd_data_valid = 1'b0;
  logic        frame_buf_sel;
  logic        busy;
  logic        overrun;
  logic [15:0] frame_cnt;

  int          n_cmp = 0;
  int          n_err = 0;

  logic        mem_en;
  int          cyc = 0;
  int          words_due = 0;
  int          due_q[$];
  logic [23:0] acc_q[$];

  frame_read_scheduler #(
    .LINE_PIXELS (8),
    .FRAME_LINES (4),
    .BURST_LEN   (8),
    .FIFO_DEPTH  (32),
    .ADDR_WIDTH  (24),
    .BASE_ADDR0  (24'h000000),
    .BASE_ADDR1  (24'h000100)
  ) dut (
    .video_clk     (video_clk),
    .rst_n         (rst_n),
    .read_req      (read_req),
    .read_req_ack  (read_req_ack),
    .wr_frame_done (wr_frame_done),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_addr      (cmd_addr),
    .cmd_len       (cmd_len),
    .fifo_level    (fifo_level),
    .rd_data_valid (rd_data_valid),
    .frame_buf_sel (frame_buf_sel),
    .busy          (busy),
    .overrun       (overrun),
    .frame_cnt     (frame_cnt)
  );

  always #5 video_clk = ~video_clk;

  // Memory: logs accepted commands, returns 8 words per command starting 3 cycles later
  always @(negedge video_clk) begin
    cyc = cyc + 1;
    if (rst_n && cmd_valid && cmd_ready) begin
      acc_q.push_back(cmd_addr);
      due_q.push_back(cyc + 3);
    end
    while (due_q.size() > 0 && due_q[0] <= cyc) begin
      void'(due_q.pop_front());
      words_due = words_due + 8;
    end
    if (mem_en && words_due > 0) begin
      rd_data_valid = 1'b1;
      words_due     = words_due - 1;
    end else begin
      rd_data_valid = 1'b0;
    end
  end

  task automatic tick();
    @(posedge video_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 300) begin
      tick();
      n++;
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ack"},  32'(read_req_ack),  32'd0);
    check({tag, "_cv"},   32'(cmd_valid),     32'd0);
    check({tag, "_addr"}, 32'(cmd_addr),      32'h0);
    check({tag, "_sel"},  32'(frame_buf_sel), 32'd0);
    check({tag, "_busy"}, 32'(busy),          32'd0);
    check({tag, "_ovr"},  32'(overrun),       32'd0);
    check({tag, "_fcnt"}, 32'(frame_cnt),     32'd0);
    check({tag, "_out"},  32'(dut.u_credit.outstanding), 32'd0);
  endtask

  // Raise read_req, expect the ack on the next edge, then release the request
  task automatic start_frame(input string tag);
    read_req = 1'b1;
    tick();
    check({tag, "_ack"}, 32'(read_req_ack), 32'd1);
    read_req = 1'b0;
  endtask

  initial begin
    int idx;
    int cnt;
    int n;
    logic saw_idle;

    rst_n         = 1'b0;
    read_req      = 1'b0;
    wr_frame_done = 1'b0;
    cmd_ready     = 1'b1;
    fifo_level    = 6'd0;
    mem_en        = 1'b1;
    repeat (3) tick();
    check_reset("rst");
    check("cmd_len", 32'(cmd_len), 32'd8);
    rst_n = 1'b1;
    tick();

    // Basic frame: four bursts from buffer 0
    idx = acc_q.size();
    read_req = 1'b1;
    tick();
    check("basic_ack", 32'(read_req_ack), 32'd1);
    check("basic_busy", 32'(busy), 32'd1);
    check("basic_cv0", 32'(cmd_valid), 32'd0);
    read_req = 1'b0;
    tick();
    check("basic_ack_pulse", 32'(read_req_ack), 32'd0);
    check("basic_cv1", 32'(cmd_valid), 32'd1);
    check("basic_addr0", 32'(cmd_addr), 32'h0);
    wait_idle("basic_idle");
    check("basic_ncmd", 32'(acc_q.size() - idx), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("basic_addr", 32'(acc_q[idx + i]), 32'(i * 8));
    end
    check("basic_fcnt", 32'(frame_cnt), 32'd1);
    check("basic_drained", 32'(words_due + due_q.size()), 32'd0);
    check("basic_out", 32'(dut.u_credit.outstanding), 32'd0);

    // Throttle: FIFO level limits issue
    idx = acc_q.size();
    mem_en = 1'b0;
    fifo_level = 6'd20;
    start_frame("thr");
    tick();
    check("thr_cv_first", 32'(cmd_valid), 32'd1);
    cnt = 0;
    repeat (6) begin
      tick();
      if (cmd_valid) cnt++;
    end
    check("thr_blocked20", 32'(cnt), 32'd0);
    check("thr_ncmd1", 32'(acc_q.size() - idx), 32'd1);
    fifo_level = 6'd17;
    cnt = 0;
    repeat (3) begin
      tick();
      if (cmd_valid) cnt++;
    end
    check("thr_blocked17", 32'(cnt), 32'd0);
    fifo_level = 6'd16;
    tick();
    check("thr_cv16", 32'(cmd_valid), 32'd1);
    fifo_level = 6'd0;
    mem_en = 1'b1;
    wait_idle("thr_idle");
    check("thr_ncmd", 32'(acc_q.size() - idx), 32'd4);
    check("thr_last_addr", 32'(acc_q[idx + 3]), 32'h18);
    check("thr_fcnt", 32'(frame_cnt), 32'd2);

    // Backpressure: command held stable while not ready
    idx = acc_q.size();
    cmd_ready = 1'b0;
    start_frame("bp");
    tick();
    check("bp_cv", 32'(cmd_valid), 32'd1);
    fifo_level = 6'd31;
    cnt = 0;
    repeat (5) begin
      tick();
      if (cmd_valid !== 1'b1 || cmd_addr !== 24'h0) cnt++;
    end
    check("bp_stable", 32'(cnt), 32'd0);
    fifo_level = 6'd0;
    cmd_ready = 1'b1;
    wait_idle("bp_idle");
    check("bp_ncmd", 32'(acc_q.size() - idx), 32'd4);
    check("bp_fcnt", 32'(frame_cnt), 32'd3);

    // Swap: two done pulses mid-frame collapse into one swap at the next frame
    start_frame("swp");
    tick();
    wr_frame_done = 1'b1;
    tick();
    wr_frame_done = 1'b0;
    tick();
    wr_frame_done = 1'b1;
    tick();
    wr_frame_done = 1'b0;
    check("swp_mid_sel", 32'(frame_buf_sel), 32'd0);
    wait_idle("swp_idle");
    check("swp_fcnt", 32'(frame_cnt), 32'd4);
    idx = acc_q.size();
    start_frame("swp2");
    check("swp2_sel_ack", 32'(frame_buf_sel), 32'd0);
    tick();
    check("swp2_sel", 32'(frame_buf_sel), 32'd1);
    check("swp2_addr", 32'(cmd_addr), 32'h100);
    wait_idle("swp2_idle");
    check("swp2_last_addr", 32'(acc_q[idx + 3]), 32'h118);
    check("swp2_fcnt", 32'(frame_cnt), 32'd5);

    // Done pulse in the ACK cycle swaps immediately
    start_frame("aswp");
    wr_frame_done = 1'b1;
    tick();
    wr_frame_done = 1'b0;
    check("aswp_sel", 32'(frame_buf_sel), 32'd0);
    check("aswp_addr", 32'(cmd_addr), 32'h0);
    wait_idle("aswp_idle");
    check("aswp_fcnt", 32'(frame_cnt), 32'd6);

    // Overrun: request during DRAIN is flagged and served once back in IDLE
    idx = acc_q.size();
    mem_en = 1'b0;
    start_frame("ovr");
    tick();
    check("ovr_no_swap", 32'(frame_buf_sel), 32'd0);
    n = 0;
    while (acc_q.size() - idx < 4 && n < 40) begin
      tick();
      n++;
    end
    tick();
    check("ovr_drain_cv", 32'(cmd_valid), 32'd0);
    check("ovr_drain_busy", 32'(busy), 32'd1);
    read_req = 1'b1;
    wr_frame_done = 1'b1;
    tick();
    wr_frame_done = 1'b0;
    check("ovr_flag", 32'(overrun), 32'd1);
    cnt = 0;
    repeat (3) begin
      tick();
      if (read_req_ack) cnt++;
    end
    check("ovr_no_ack", 32'(cnt), 32'd0);
    mem_en = 1'b1;
    n = 0;
    saw_idle = 1'b0;
    while (!read_req_ack && n < 200) begin
      tick();
      n++;
      if (!busy) saw_idle = 1'b1;
    end
    check("ovr_late_ack", 32'(read_req_ack), 32'd1);
    check("ovr_saw_idle", 32'(saw_idle), 32'd1);
    check("ovr_sticky", 32'(overrun), 32'd1);
    check("ovr_fcnt", 32'(frame_cnt), 32'd7);
    read_req = 1'b0;
    tick();
    check("ovr_next_sel", 32'(frame_buf_sel), 32'd1);
    check("ovr_next_addr", 32'(cmd_addr), 32'h100);

    // Reset mid-ISSUE with words in flight; stale returns afterwards are ignored
    mem_en = 1'b0;
    tick();
    tick();
    check("mid_out", 32'(dut.u_credit.outstanding), 32'd16);
    rst_n = 1'b0;
    tick();
    check_reset("mid_rst");
    rst_n = 1'b1;
    mem_en = 1'b1;
    repeat (25) tick();
    check("stale_done", 32'(words_due), 32'd0);
    check("stale_out", 32'(dut.u_credit.outstanding), 32'd0);
    check("stale_cv", 32'(cmd_valid), 32'd0);
    check("stale_busy", 32'(busy), 32'd0);
    check("stale_fcnt", 32'(frame_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
